draw_rect_bounce: RTL and testbench

Pipeline stage placed after the background generator on the vga_bus chain. It overlays a solid, parametrised rectangle on the incoming pixel stream and passes all timing signals through unchanged. The rectangle position is held in registers and advanced once per frame. It bounces off the visible-area edges, so it gives the display path a moving test pattern.

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_bus.sv | 33 +++
 rtl/bounce_axis.sv | 67 ++++++
 rtl/draw_rect_bounce.sv | 129 ++++++++++++
 tb/tb_draw_rect_bounce.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared display constants and types for the vga_bus pipeline stages.
// Also holds the rectangle-span helpers used by the overlay stages.
package vga_pkg;

    // Visible area of the display mode carried on vga_bus.
    localparam int VISIBLE_WIDTH  = 800;
    localparam int VISIBLE_HEIGHT = 600;

    // Colour used for the optional 1-pixel rectangle outline.
    localparam logic [11:0] COLOR_BORDER = 12'hf_f_f;

    // Direction of travel along one axis.
    typedef enum logic {
        FWD = 1'b0,
        REV = 1'b1
    } dir_t;

    // True when coord lies in [lo, lo+size); 12-bit math so lo+size cannot wrap.
    function automatic logic in_span(input logic [10:0] coord,
                                     input logic [10:0] lo,
                                     input logic [11:0] size);
        logic [11:0] c12;
        logic [11:0] lo12;
        c12  = {1'b0, coord};
        lo12 = {1'b0, lo};
        return (c12 >= lo12) && (c12 < (lo12 + size));
    endfunction

    // True when coord is the first or last position of [lo, lo+size).
    function automatic logic on_edge(input logic [10:0] coord,
                                     input logic [10:0] lo,
                                     input logic [11:0] size);
        logic [11:0] c12;
        logic [11:0] lo12;
        c12  = {1'b0, coord};
        lo12 = {1'b0, lo};
        return (c12 == lo12) || (c12 == (lo12 + size - 12'd1));
    endfunction

endpackage

// File: rtl/vga_bus.sv
// vga_bus: pixel coordinates, sync/blank strobes and 12-bit RGB.
// mp_in is the consumer view, mp_out the producer view.
interface vga_bus;

    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport mp_in (
        input vcount,
        input hcount,
        input vsync,
        input hsync,
        input vblnk,
        input hblnk,
        input rgb
    );

    modport mp_out (
        output vcount,
        output hcount,
        output vsync,
        output hsync,
        output vblnk,
        output hblnk,
        output rgb
    );

endinterface

// File: rtl/bounce_axis.sv
// bounce_axis: one axis of the bouncing rectangle.
// Holds the top-left coordinate and a FWD/REV direction; on each enabled
// frame tick it steps by STEP and clamps + reverses at 0 or LIMIT-SIZE.
module bounce_axis
    import vga_pkg::*;
#(
    parameter int SIZE  = 64,
    parameter int LIMIT = VISIBLE_WIDTH,
    parameter int STEP  = 2,
    parameter int INIT  = 100
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        enable,
    output logic [10:0] pos,
    output dir_t        dir
);

    localparam logic [11:0] C_SIZE   = 12'(SIZE);
    localparam logic [11:0] C_LIMIT  = 12'(LIMIT);
    localparam logic [11:0] C_STEP   = 12'(STEP);
    localparam logic [10:0] C_STEP11 = 11'(STEP);
    localparam logic [10:0] C_MAX    = 11'(LIMIT - SIZE);
    localparam logic [10:0] C_INIT   = 11'(INIT);

    logic [10:0] r_pos;
    dir_t        r_dir;
    logic [11:0] w_pos_ext;
    logic        w_fwd_hit;
    logic        w_rev_hit;

    // Edge detection in 12 bits: pos+SIZE+STEP stays below 4096.
    always_comb begin
        w_pos_ext = {1'b0, r_pos};
        w_fwd_hit = (w_pos_ext + C_SIZE + C_STEP) >= C_LIMIT;
        w_rev_hit = w_pos_ext <= C_STEP;
    end

    // Position/direction register: moves only on an enabled frame tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos <= C_INIT;
            r_dir <= FWD;
        end else if (tick && enable) begin
            if (r_dir == FWD) begin
                if (w_fwd_hit) begin
                    r_pos <= C_MAX;
                    r_dir <= REV;
                end else begin
                    r_pos <= r_pos + C_STEP11;
                end
            end else begin
                if (w_rev_hit) begin
                    r_pos <= '0;
                    r_dir <= FWD;
                end else begin
                    r_pos <= r_pos - C_STEP11;
                end
            end
        end
    end

    assign pos = r_pos;
    assign dir = r_dir;

endmodule

// File: rtl/draw_rect_bounce.sv
// draw_rect_bounce: overlays a solid rectangle on the vga_bus pixel stream.
// All bus fields are registered once (1-cycle latency). The rectangle
// position advances once per frame, at the start of vertical blanking,
// and bounces off the visible-area edges.
// Optional: define DRAW_RECT_BORDER_EN to draw a 1-pixel COLOR_BORDER outline.
module draw_rect_bounce
    import vga_pkg::*;
#(
    parameter int          RECT_W   = 64,
    parameter int          RECT_H   = 48,
    parameter int          STEP     = 2,
    parameter int          X_INIT   = 100,
    parameter int          Y_INIT   = 80,
    parameter logic [11:0] RECT_RGB = 12'hf_8_0
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         visible,
    vga_bus.mp_in        bus_in,
    vga_bus.mp_out       bus_out,
    output logic [10:0]  x_pos,
    output logic [10:0]  y_pos
);

    localparam logic [11:0] C_RECT_W = 12'(RECT_W);
    localparam logic [11:0] C_RECT_H = 12'(RECT_H);

    logic        r_vblnk_d;
    logic        w_tick;
    logic [10:0] w_x_pos;
    logic [10:0] w_y_pos;
    // Directions are only probed hierarchically for debug.
    dir_t        w_dir_x_unused;
    dir_t        w_dir_y_unused;
    logic        w_in_rect;
    logic [11:0] w_rgb_nxt;
`ifdef DRAW_RECT_BORDER_EN
    logic        w_on_border;
`endif

    // Delayed vblnk for the start-of-blanking edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnk_d <= 1'b0;
        end else begin
            r_vblnk_d <= bus_in.vblnk;
        end
    end

    assign w_tick = bus_in.vblnk & ~r_vblnk_d;

    bounce_axis #(
        .SIZE  (RECT_W),
        .LIMIT (VISIBLE_WIDTH),
        .STEP  (STEP),
        .INIT  (X_INIT)
    ) u_axis_x (
        .clk    (clk),
        .rst    (rst),
        .tick   (w_tick),
        .enable (enable),
        .pos    (w_x_pos),
        .dir    (w_dir_x_unused)
    );

    bounce_axis #(
        .SIZE  (RECT_H),
        .LIMIT (VISIBLE_HEIGHT),
        .STEP  (STEP),
        .INIT  (Y_INIT)
    ) u_axis_y (
        .clk    (clk),
        .rst    (rst),
        .tick   (w_tick),
        .enable (enable),
        .pos    (w_y_pos),
        .dir    (w_dir_y_unused)
    );

    // Pixel select against the current (frame-stable) rectangle position.
    always_comb begin
        w_in_rect = in_span(bus_in.hcount, w_x_pos, C_RECT_W) &&
                    in_span(bus_in.vcount, w_y_pos, C_RECT_H);
`ifdef DRAW_RECT_BORDER_EN
        w_on_border = on_edge(bus_in.hcount, w_x_pos, C_RECT_W) ||
                      on_edge(bus_in.vcount, w_y_pos, C_RECT_H);
`endif
    end

    // Next pixel colour: blanking forces black, then rectangle, else pass-through.
    always_comb begin
        w_rgb_nxt = bus_in.rgb;
        if (bus_in.vblnk || bus_in.hblnk) begin
            w_rgb_nxt = '0;
        end else if (visible && w_in_rect) begin
`ifdef DRAW_RECT_BORDER_EN
            w_rgb_nxt = w_on_border ? COLOR_BORDER : RECT_RGB;
`else
            w_rgb_nxt = RECT_RGB;
`endif
        end
    end

    // Output stage: one register for every bus field.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_out.vcount <= '0;
            bus_out.hcount <= '0;
            bus_out.vsync  <= 1'b0;
            bus_out.hsync  <= 1'b0;
            bus_out.vblnk  <= 1'b0;
            bus_out.hblnk  <= 1'b0;
            bus_out.rgb    <= '0;
        end else begin
            bus_out.vcount <= bus_in.vcount;
            bus_out.hcount <= bus_in.hcount;
            bus_out.vsync  <= bus_in.vsync;
            bus_out.hsync  <= bus_in.hsync;
            bus_out.vblnk  <= bus_in.vblnk;
            bus_out.hblnk  <= bus_in.hblnk;
            bus_out.rgb    <= w_rgb_nxt;
        end
    end

    assign x_pos = w_x_pos;
    assign y_pos = w_y_pos;

endmodule

// File: tb/tb_draw_rect_bounce.sv
// Bench for draw_rect_bounce: three instances (default, right-edge start,
// corner-aligned) share one synthetic pixel stream with short frames.
// A per-instance position/colour model predicts every output each cycle.
module tb_draw_rect_bounce;
    import vga_pkg::*;

    localparam int STEP = 2;

`ifdef DRAW_RECT_BORDER_EN
    localparam int EXP_TL  = 'hfff;
    localparam int EXP_BR  = 'hfff;
`else
    localparam int EXP_TL  = 'hf80;
    localparam int EXP_BR  = 'hf80;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic enable;
    logic visible;

    vga_bus bus_in ();
    vga_bus bus_out0 ();
    vga_bus bus_out1 ();
    vga_bus bus_out2 ();

    logic [10:0] x0, y0, x1, y1, x2, y2;

    draw_rect_bounce dut0 (
        .clk (clk), .rst (rst), .enable (enable), .visible (visible),
        .bus_in (bus_in), .bus_out (bus_out0), .x_pos (x0), .y_pos (y0)
    );

    draw_rect_bounce #(.X_INIT(735)) dut1 (
        .clk (clk), .rst (rst), .enable (enable), .visible (visible),
        .bus_in (bus_in), .bus_out (bus_out1), .x_pos (x1), .y_pos (y1)
    );

    draw_rect_bounce #(.RECT_W(248), .X_INIT(551), .Y_INIT(551)) dut2 (
        .clk (clk), .rst (rst), .enable (enable), .visible (visible),
        .bus_in (bus_in), .bus_out (bus_out2), .x_pos (x2), .y_pos (y2)
    );

    // Reference model state
    int P_W  [3] = '{64, 64, 248};
    int P_H  [3] = '{48, 48, 48};
    int P_XI [3] = '{100, 735, 551};
    int P_YI [3] = '{80, 80, 551};
    int m_x [3];
    int m_y [3];
    int m_dx[3];
    int m_dy[3];
    logic m_vbd;
    bit   corner_flag;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_x[k] = P_XI[k]; m_y[k] = P_YI[k];
            m_dx[k] = 1;      m_dy[k] = 1;
        end
        m_vbd = 1'b0;
    endtask

    // One frame of motion: move by STEP, clamp + turn around at either wall.
    task automatic move_axis(inout int p, inout int d, input int size, input int limit);
        int n;
        n = p + STEP * d;
        if (d > 0 && n + size >= limit) begin
            p = limit - size; d = -1;
        end else if (d < 0 && n <= 0) begin
            p = 0; d = 1;
        end else begin
            p = n;
        end
    endtask

    task automatic model_move(input int k);
        bit both_rev;
        both_rev = (m_dx[k] < 0) && (m_dy[k] < 0);
        move_axis(m_x[k], m_dx[k], P_W[k], VISIBLE_WIDTH);
        move_axis(m_y[k], m_dy[k], P_H[k], VISIBLE_HEIGHT);
        if (k == 2 && both_rev && m_dx[k] > 0 && m_dy[k] > 0) corner_flag = 1'b1;
    endtask

    function automatic int exp_rgb(input int k, input int h, input int v,
                                   input logic vb, input logic hb,
                                   input logic vis, input int rgbv);
        if (vb || hb) return 0;
        if (vis && h >= m_x[k] && h < m_x[k] + P_W[k] &&
                   v >= m_y[k] && v < m_y[k] + P_H[k]) begin
`ifdef DRAW_RECT_BORDER_EN
            if (h == m_x[k] || h == m_x[k] + P_W[k] - 1 ||
                v == m_y[k] || v == m_y[k] + P_H[k] - 1) return 'hfff;
`endif
            return 'hf80;
        end
        return rgbv;
    endfunction

    task automatic read_out(input int k, output int tim, output int rgbo,
                            output int xo, output int yo);
        case (k)
            0: begin
                tim  = int'({bus_out0.vcount, bus_out0.hcount, bus_out0.vsync,
                             bus_out0.hsync, bus_out0.vblnk, bus_out0.hblnk});
                rgbo = int'(bus_out0.rgb); xo = int'(x0); yo = int'(y0);
            end
            1: begin
                tim  = int'({bus_out1.vcount, bus_out1.hcount, bus_out1.vsync,
                             bus_out1.hsync, bus_out1.vblnk, bus_out1.hblnk});
                rgbo = int'(bus_out1.rgb); xo = int'(x1); yo = int'(y1);
            end
            default: begin
                tim  = int'({bus_out2.vcount, bus_out2.hcount, bus_out2.vsync,
                             bus_out2.hsync, bus_out2.vblnk, bus_out2.hblnk});
                rgbo = int'(bus_out2.rgb); xo = int'(x2); yo = int'(y2);
            end
        endcase
    endtask

    // Drive one pixel, advance one clock, check every instance.
    task automatic cycle(input logic r, input logic vb, input logic hb,
                         input int h, input int v, input int rgbv);
        logic [10:0] hh, vv;
        logic vs, hs;
        int e_tim;
        int e_rgb[3];
        int o_tim, o_rgb, o_x, o_y;
        hh = 11'(h);
        vv = 11'(v);
        vs = 1'($urandom_range(0, 1));
        hs = 1'($urandom_range(0, 1));
        rst            = r;
        bus_in.hcount  = hh;
        bus_in.vcount  = vv;
        bus_in.vsync   = vs;
        bus_in.hsync   = hs;
        bus_in.vblnk   = vb;
        bus_in.hblnk   = hb;
        bus_in.rgb     = 12'(rgbv);
        e_tim = r ? 0 : int'({vv, hh, vs, hs, vb, hb});
        for (int k = 0; k < 3; k++)
            e_rgb[k] = r ? 0 : exp_rgb(k, int'(hh), int'(vv), vb, hb, visible, rgbv & 'hfff);
        if (r) begin
            model_reset();
        end else begin
            if (vb && !m_vbd && enable)
                for (int k = 0; k < 3; k++) model_move(k);
            m_vbd = vb;
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            read_out(k, o_tim, o_rgb, o_x, o_y);
            check_eq($sformatf("timing%0d", k), o_tim, e_tim);
            check_eq($sformatf("rgb%0d", k), o_rgb, e_rgb[k]);
            check_eq($sformatf("x_pos%0d", k), o_x, m_x[k]);
            check_eq($sformatf("y_pos%0d", k), o_y, m_y[k]);
        end
        if (corner_flag) begin
            corner_flag = 1'b0;
            check_eq("corner_x", int'(x2), 0);
            check_eq("corner_y", int'(y2), 0);
            check_eq("corner_dir_x", int'(dut2.u_axis_x.dir), int'(FWD));
            check_eq("corner_dir_y", int'(dut2.u_axis_y.dir), int'(FWD));
        end
    endtask

    task automatic run_frame(input int n_act, input int n_blank, input bit bias);
        int h, v;
        for (int i = 0; i < n_act; i++) begin
            if (bias) begin
                h = m_x[0] - 1 + int'($urandom_range(0, P_W[0] + 1));
                v = m_y[0] - 1 + int'($urandom_range(0, P_H[0] + 1));
                if (h < 0) h = 0;
                if (v < 0) v = 0;
            end else begin
                h = int'($urandom_range(0, 1055));
                v = int'($urandom_range(0, 627));
            end
            cycle(1'b0, 1'b0, ($urandom_range(0, 7) == 0), h, v, int'($urandom_range(0, 4095)));
        end
        for (int i = 0; i < n_blank; i++)
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1055)), int'($urandom_range(600, 627)),
                  int'($urandom_range(0, 4095)));
    endtask

    initial begin
        corner_flag = 1'b0;
        enable  = 1'b0;
        visible = 1'b1;
        model_reset();

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 5, 5, 'h123);

        // Frozen frame, then directed pixels around the top-left corner
        run_frame(20, 4, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 100, 80, 'h123);
        check_eq("px_100_80", int'(bus_out0.rgb), EXP_TL);
        cycle(1'b0, 1'b0, 1'b0, 99, 80, 'h5a5);
        check_eq("px_99_80", int'(bus_out0.rgb), 'h5a5);
        cycle(1'b0, 1'b0, 1'b0, 164, 80, 'h0f1);
        check_eq("px_164_80", int'(bus_out0.rgb), 'h0f1);
        cycle(1'b0, 1'b0, 1'b0, 100, 128, 'h777);
        check_eq("px_100_128", int'(bus_out0.rgb), 'h777);
        cycle(1'b0, 1'b0, 1'b0, 101, 81, 'h777);
        check_eq("px_101_81", int'(bus_out0.rgb), 'hf80);
        cycle(1'b0, 1'b0, 1'b0, 163, 127, 'h777);
        check_eq("px_163_127", int'(bus_out0.rgb), EXP_BR);

        // Ten moving frames
        enable = 1'b1;
        for (int f = 0; f < 10; f++) begin
            run_frame(20, 4, 1'b1);
            if (f == 0) begin
                check_eq("edge_x_tick1", int'(x1), VISIBLE_WIDTH - 64);
                check_eq("edge_dir_tick1", int'(dut1.u_axis_x.dir), int'(REV));
            end
            if (f == 1) begin
                check_eq("edge_x_tick2", int'(x1), VISIBLE_WIDTH - 64 - 2);
                check_eq("edge_dir_tick2", int'(dut1.u_axis_x.dir), int'(REV));
            end
        end
        check_eq("x_after_10", int'(x0), 120);
        check_eq("y_after_10", int'(y0), 100);

        // Invisible frame: pure pass-through
        visible = 1'b0;
        run_frame(24, 4, 1'b1);
        visible = 1'b1;

        // Reset in the middle of a line
        run_frame(8, 0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 300, 200, 'habc);
        check_eq("rst_rgb", int'(bus_out0.rgb), 0);
        check_eq("rst_hcount", int'(bus_out0.hcount), 0);
        check_eq("rst_x", int'(x0), 100);
        check_eq("rst_y", int'(y0), 80);
        run_frame(12, 4, 1'b1);
        check_eq("x_after_rst_tick", int'(x0), 102);

        // Randomized long run: bounces on all instances, corner on dut2
        for (int f = 0; f < 450; f++) begin
            enable  = ($urandom_range(0, 19) != 0);
            visible = ($urandom_range(0, 9) != 0);
            run_frame(int'($urandom_range(8, 30)), int'($urandom_range(2, 6)), f[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
